instr_mem_fetch: RTL and testbench

- Parametrised instruction memory with a fetch handshake; successor of the fixed 4-bank, 5-bit-address instruction store.
- Four byte-wide banks (bank_3 = bits 31:24 … bank_0 = bits 7:0) hold up to DEPTH_WORDS 32-bit words.
- Fetch stage reads it through a valid/ready request/response pair; a byte-enabled load port writes program images with no hardcoded contents.
- Adds alignment and range fault reporting, backpressure and flush.

---
 rtl/instr_mem_fetch.sv | 98 +++++++++
 tb/tb_instr_mem_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Byte-banked instruction memory with a valid/ready fetch port and a byte-enabled program-load port.
// Responses are registered one cycle after accept and carry misalignment / out-of-range fault flags.
module instr_mem_fetch #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 4096,
   parameter int WORD_IDX_W  = $clog2(DEPTH_WORDS)
) (
   input  logic                  instr_mem_clk,
   input  logic                  instr_mem_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic [1:0]            rsp_fault,
   input  logic                  flush,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [31:0]           load_data,
   input  logic [3:0]            load_be
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state_q, state_d;

   logic [7:0] bank_0 [DEPTH_WORDS];
   logic [7:0] bank_1 [DEPTH_WORDS];
   logic [7:0] bank_2 [DEPTH_WORDS];
   logic [7:0] bank_3 [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] req_word, load_word;
   logic [WORD_IDX_W-1:0] req_idx, load_idx;
   logic                  req_oor, load_oor;
   logic [1:0]            req_fault;
   logic                  accept;

   // Word address: upper bits beyond the index width mean the address lies past the array.
   assign req_word  = req_addr >> 2;
   assign load_word = load_addr >> 2;
   assign req_idx   = req_word[WORD_IDX_W-1:0];
   assign load_idx  = load_word[WORD_IDX_W-1:0];
   assign req_oor   = (req_word >> WORD_IDX_W) != '0;
   assign load_oor  = (load_word >> WORD_IDX_W) != '0;
   assign req_fault = {req_oor, req_addr[1:0] != 2'b00};

   assign rsp_valid = (state_q == FULL);
   assign req_ready = !instr_mem_rst && !load_en && !flush && (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;

   always_ff @(posedge instr_mem_clk) begin
      if (load_en && !load_oor) begin
         if (load_be[0]) bank_0[load_idx] <= load_data[7:0];
         if (load_be[1]) bank_1[load_idx] <= load_data[15:8];
         if (load_be[2]) bank_2[load_idx] <= load_data[23:16];
         if (load_be[3]) bank_3[load_idx] <= load_data[31:24];
      end
   end

   always_ff @(posedge instr_mem_clk or posedge instr_mem_rst) begin
      if (instr_mem_rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = FULL;
      end else if (rsp_ready) begin
         state_d = EMPTY;
      end
   end

   // Response payload only moves on accept, so it stays frozen under backpressure.
   always_ff @(posedge instr_mem_clk or posedge instr_mem_rst) begin
      if (instr_mem_rst) begin
         rsp_data  <= '0;
         rsp_addr  <= '0;
         rsp_fault <= '0;
      end else if (accept) begin
         rsp_addr  <= req_addr;
         rsp_fault <= req_fault;
         if (req_fault != 2'b00) begin
            rsp_data <= '0;
         end else begin
            rsp_data <= {bank_3[req_idx], bank_2[req_idx], bank_1[req_idx], bank_0[req_idx]};
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: load, fetch, backpressure, byte enables, faults, flush, reset.
module tb_instr_mem_fetch;

   localparam int ADDR_WIDTH  = 32;
   localparam int DEPTH_WORDS = 4096;

   logic                  instr_mem_clk;
   logic                  instr_mem_rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_data;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [1:0]            rsp_fault;
   logic                  flush;
   logic                  load_en;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [31:0]           load_data;
   logic [3:0]            load_be;

   int n_chk;
   int n_err;

   instr_mem_fetch #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH_WORDS(DEPTH_WORDS)
   ) dut (
      .instr_mem_clk(instr_mem_clk),
      .instr_mem_rst(instr_mem_rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_addr     (rsp_addr),
      .rsp_fault    (rsp_fault),
      .flush        (flush),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_be      (load_be)
   );

   initial begin
      instr_mem_clk = 1'b0;
      forever #5 instr_mem_clk = ~instr_mem_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge instr_mem_clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      load_en   = 1'b1;
      load_addr = addr;
      load_data = data;
      load_be   = be;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] data, input logic [31:0] addr,
                          input logic [1:0] fault);
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_data"},  rsp_data, data);
      chk({tag, "_addr"},  rsp_addr, addr);
      chk({tag, "_fault"}, {30'd0, rsp_fault}, {30'd0, fault});
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      instr_mem_rst = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      load_be   = '0;
      tick();
      tick();
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_data",  rsp_data, 32'd0);
      chk("rst_addr",  rsp_addr, 32'd0);
      chk("rst_fault", {30'd0, rsp_fault}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      instr_mem_rst = 1'b0;
      tick();

      // program image and streaming fetch
      load_word(32'h0, 32'h001A0003, 4'hF);
      load_word(32'h4, 32'h0011A083, 4'hF);
      load_word(32'h8, 32'h00810133, 4'hF);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      #1;
      chk("stream_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk_rsp("stream0", 32'h001A0003, 32'h0, 2'b00);
      req_addr = 32'h4;
      tick();
      chk_rsp("stream1", 32'h0011A083, 32'h4, 2'b00);
      req_addr = 32'h8;
      tick();
      chk_rsp("stream2", 32'h00810133, 32'h8, 2'b00);
      req_valid = 1'b0;
      tick();
      chk("stream_drain", {31'd0, rsp_valid}, 32'd0);

      // backpressure
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      tick();
      chk_rsp("bp_first", 32'h001A0003, 32'h0, 2'b00);
      req_addr = 32'h4;
      #1;
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_hold_data", rsp_data, 32'h001A0003);
         chk("bp_ready_held", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_ready_rise", {31'd0, req_ready}, 32'd1);
      tick();
      chk_rsp("bp_second", 32'h0011A083, 32'h4, 2'b00);
      req_valid = 1'b0;
      tick();
      chk("bp_drain", {31'd0, rsp_valid}, 32'd0);

      // byte enables
      load_word(32'h10, 32'hFFFFFFFF, 4'hF);
      load_word(32'h10, 32'h12345678, 4'b0101);
      req_valid = 1'b1;
      req_addr  = 32'h10;
      tick();
      chk_rsp("be_merge", 32'hFF34FF78, 32'h10, 2'b00);

      // faults, back-to-back
      req_addr = 32'h2;
      tick();
      chk_rsp("flt_mis", 32'h0, 32'h2, 2'b01);
      req_addr = DEPTH_WORDS * 4;
      tick();
      chk_rsp("flt_oor", 32'h0, DEPTH_WORDS * 4, 2'b10);
      req_addr = DEPTH_WORDS * 4 + 1;
      tick();
      chk_rsp("flt_both", 32'h0, DEPTH_WORDS * 4 + 1, 2'b11);
      req_valid = 1'b0;
      tick();
      chk("flt_drain", {31'd0, rsp_valid}, 32'd0);

      // load priority over fetch
      req_valid = 1'b1;
      req_addr  = 32'h0;
      load_en   = 1'b1;
      load_addr = 32'h20;
      load_data = 32'hDEADBEEF;
      load_be   = 4'hF;
      #1;
      chk("prio_ready", {31'd0, req_ready}, 32'd0);
      tick();
      load_en = 1'b0;
      chk("prio_no_rsp", {31'd0, rsp_valid}, 32'd0);

      // flush beats rsp_ready on a held response
      rsp_ready = 1'b0;
      req_addr  = 32'h4;
      tick();
      chk_rsp("fl_held", 32'h0011A083, 32'h4, 2'b00);
      flush     = 1'b1;
      rsp_ready = 1'b1;
      req_addr  = 32'h8;
      #1;
      chk("fl_ready", {31'd0, req_ready}, 32'd0);
      tick();
      flush     = 1'b0;
      req_valid = 1'b0;
      chk("fl_dropped", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("fl_still_empty", {31'd0, rsp_valid}, 32'd0);

      // async reset while a response is held
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h8;
      tick();
      chk_rsp("ar_held", 32'h00810133, 32'h8, 2'b00);
      req_valid = 1'b0;
      #2;
      instr_mem_rst = 1'b1;
      #1;
      chk("ar_valid", {31'd0, rsp_valid}, 32'd0);
      chk("ar_data", rsp_data, 32'd0);
      chk("ar_fault", {30'd0, rsp_fault}, 32'd0);
      tick();
      instr_mem_rst = 1'b0;
      tick();
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0;
      tick();
      chk_rsp("ar_mem_kept", 32'h001A0003, 32'h0, 2'b00);
      req_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
